branch_redirect_ctrl: RTL and testbench
=======================================

Name: branch_redirect_ctrl

Overview:
- Sequencing controller between the per-slot branch execute units of a VLIW bundle and the front end (fetch/decode) and execute stage.
- Each cycle it collects branch/jump/halt results from up to N_BR branch slots and picks the oldest one in program order.
- On a redirect it issues registered squash pulses, then holds a valid/ready redirect to fetch.
- After fetch accepts, it drains wrong-path results for a programmable number of cycles.
- A halt request latches a sticky processor halt.

Parameters:
- N_BR, 2, number of branch slots per bundle; slot 0 is oldest.
- DRAIN_CYCLES, 2, cycles after the redirect handshake during which branch inputs are ignored; 0 is legal.
- PC_W, 32, PC / target width.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- br_valid  input  N_BR  slot carries a real (non-nop) branch-unit result this cycle
- br_taken  input  N_BR  slot's branch/jump taken
- br_new_pc  input  N_BR*PC_W  slot target; slot i at bits [i*PC_W +: PC_W]
- br_dont_squash_dec  input  N_BR  target lies in the bundle now in decode; keep decode
- br_dont_squash_exec  input  N_BR  target lies in the bundle now in execute; keep execute
- br_halt  input  N_BR  ecall/ebreak halt request
- fetch_ready  input  1  fetch accepts redirect this cycle
- redirect_valid  output  1  redirect_pc valid toward fetch
- redirect_pc  output  PC_W  redirect target
- squash_fetch  output  1  one-cycle kill of the fetch-stage bundle
- squash_dec  output  1  one-cycle kill of the decode-stage bundle
- squash_exec  output  1  one-cycle kill of younger execute-stage work
- stall_front  output  1  freeze fetch/decode
- halted  output  1  sticky processor halt

Behaviour:
- Reset: clk is the single clock; rst_n is asynchronous and active-low.
  - On assertion, state=RUN, drain counter=0, and all outputs are 0 (redirect_pc=0).
  - Reset mid-redirect or mid-drain abandons the pending redirect.
- Winner selection (RUN only, combinational): lowest index i with br_valid[i] && (br_halt[i] || br_taken[i]). Slots above the winner are ignored.
- States: RUN, REDIRECT, DRAIN, HALT.
- RUN:
  - No winner: all outputs 0, remain in RUN.
  - Winner is a halt: next cycle squash_fetch=1 and squash_dec=1 (one cycle), squash_exec=0; halted=1 from the next cycle onward; go to HALT.
  - Winner is taken (no halt):
    - Register redirect_pc <= winner's new_pc, unmodified and with no alignment.
    - Next cycle, for exactly one cycle: squash_fetch=1, squash_dec=~dont_squash_dec[i], squash_exec=~dont_squash_exec[i].
    - Go to REDIRECT.
- REDIRECT:
  - redirect_valid=1 and stall_front=1; redirect_pc is held stable.
  - All br_* inputs are ignored, since they are wrong-path.
  - When fetch_ready=1 (handshake): redirect_valid drops next cycle.
    - DRAIN_CYCLES>0: load counter=DRAIN_CYCLES and go to DRAIN.
    - DRAIN_CYCLES=0: go to RUN.
  - fetch_ready may already be high on the first REDIRECT cycle, giving a 1-cycle redirect.
- DRAIN:
  - stall_front=0; br_* inputs are ignored.
  - Counter decrements each cycle; at 1 the state goes to RUN next cycle.
  - Drain length is exactly DRAIN_CYCLES cycles.
- HALT:
  - halted=1 and stall_front=1; all other outputs 0.
  - Only rst_n exits HALT.
- Latency:
  - Winner cycle to squash pulse: 1 cycle.
  - Winner cycle to first redirect_valid: 1 cycle; squash and redirect_valid first rise in the same cycle.
- Simultaneous events:
  - Halt in a slot older than a taken branch: halt wins.
  - Taken branch in an older slot than a halt: redirect, and the halt is discarded.
  - Taken branch and halt in the same slot: halt wins.

Optional Feature:
- Macro: BR_REDIRECT_STATS_EN.
- When defined:
  - Adds output taken_cnt (32) and output squash_cnt (32).
  - taken_cnt increments once per accepted redirect handshake.
  - squash_cnt increments by the number of squash_* bits set in each squash cycle.
  - Both reset to 0, saturate at all-ones, and freeze in HALT.
- When undefined: neither port nor logic exists, and behaviour is otherwise identical.

Decomposition:
- Shared package br_ctrl_pkg holds:
  - typedef enum logic [1:0] br_ctrl_state_e {RUN, REDIRECT, DRAIN, HALT};
  - constant BUNDLE_BYTES=16.
- One natural sub-module: br_oldest_sel. It is a parameterised priority selector returning the winner index, a winner-valid flag and an is-halt flag.

Test Plan:
- Slot0 taken with new_pc=0x0000_0140, dont_squash_dec=0, dont_squash_exec=0, fetch_ready=1 one cycle later → next cycle squash_fetch=squash_dec=squash_exec=1 and redirect_valid=1 with redirect_pc=0x140; then 2 drain cycles; back to RUN.
- Slot1 taken to 0x200 with dont_squash_dec=1, fetch_ready low for 3 cycles → squash_dec=0 while squash_fetch=1 and squash_exec=1; redirect_valid and redirect_pc held for 4 cycles.
- Slot0 taken to 0x80 and slot1 halt in the same cycle → redirect to 0x80; halted stays 0.
- Slot0 halt and slot1 taken → halted=1 from the next cycle and stays 1; a new br_valid/br_taken input 5 cycles later produces no redirect; deasserting rst_n clears halted.
- Taken branch presented during REDIRECT and during DRAIN → ignored; redirect_pc unchanged; no second squash.
- rst_n pulsed while in REDIRECT → all outputs 0 immediately (asynchronous); state RUN after release.

Source files
------------

// File: rtl/br_ctrl_pkg.sv
// Shared types and helpers for the branch redirect controller.
// Stats helper is used only when BR_REDIRECT_STATS_EN is defined.
package br_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    REDIRECT = 2'd1,
    DRAIN    = 2'd2,
    HALT     = 2'd3
  } br_ctrl_state_e;

  localparam int BUNDLE_BYTES = 16;

  // Saturating 32-bit add for event counters.
  function automatic logic [31:0] sat_add32(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[32] ? 32'hFFFF_FFFF : sum[31:0];
  endfunction

endpackage

// File: rtl/br_oldest_sel.sv
// Priority selector: picks the oldest slot (lowest index) with a taken branch or a halt.
module br_oldest_sel #(
  parameter int N     = 2,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     valid_i,
  input  logic [N-1:0]     taken_i,
  input  logic [N-1:0]     halt_i,
  output logic [IDX_W-1:0] idx_o,
  output logic             win_valid_o,
  output logic             win_halt_o
);

  logic [N-1:0] cand_s;

  // Walk from youngest to oldest so the oldest candidate overwrites the rest.
  always_comb begin
    cand_s      = valid_i & (halt_i | taken_i);
    idx_o       = '0;
    win_valid_o = 1'b0;
    win_halt_o  = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      idx_o       = cand_s[i] ? IDX_W'(i) : idx_o;
      win_halt_o  = cand_s[i] ? halt_i[i] : win_halt_o;
      win_valid_o = win_valid_o | cand_s[i];
    end
  end

endmodule

// File: rtl/branch_redirect_ctrl.sv
// Branch redirect sequencer: oldest-slot select, squash pulses, redirect handshake, drain, sticky halt.
// Optional counters taken_cnt/squash_cnt exist only when BR_REDIRECT_STATS_EN is defined.
module branch_redirect_ctrl
  import br_ctrl_pkg::*;
#(
  parameter int N_BR         = 2,
  parameter int DRAIN_CYCLES = 2,
  parameter int PC_W         = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N_BR-1:0]      br_valid,
  input  logic [N_BR-1:0]      br_taken,
  input  logic [N_BR*PC_W-1:0] br_new_pc,
  input  logic [N_BR-1:0]      br_dont_squash_dec,
  input  logic [N_BR-1:0]      br_dont_squash_exec,
  input  logic [N_BR-1:0]      br_halt,
  input  logic                 fetch_ready,
  output logic                 redirect_valid,
  output logic [PC_W-1:0]      redirect_pc,
  output logic                 squash_fetch,
  output logic                 squash_dec,
  output logic                 squash_exec,
  output logic                 stall_front,
  output logic                 halted
`ifdef BR_REDIRECT_STATS_EN
  ,
  output logic [31:0]          taken_cnt,
  output logic [31:0]          squash_cnt
`endif
);

  localparam int CNT_W = (DRAIN_CYCLES > 0) ? $clog2(DRAIN_CYCLES + 1) : 1;
  localparam int IDX_W = (N_BR > 1) ? $clog2(N_BR) : 1;
  localparam logic [CNT_W-1:0] DRAIN_LOAD = CNT_W'(DRAIN_CYCLES);

  br_ctrl_state_e   state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic             rv_q, rv_d;
  logic             sq_f_q, sq_f_d;
  logic             sq_d_q, sq_d_d;
  logic             sq_e_q, sq_e_d;
  logic             stall_q, stall_d;
  logic             halted_q, halted_d;

  logic [IDX_W-1:0] win_idx_s;
  logic             win_valid_s;
  logic             win_halt_s;
  logic [PC_W-1:0]  win_pc_s;

  br_oldest_sel #(.N(N_BR), .IDX_W(IDX_W)) u_sel (
    .valid_i     (br_valid),
    .taken_i     (br_taken),
    .halt_i      (br_halt),
    .idx_o       (win_idx_s),
    .win_valid_o (win_valid_s),
    .win_halt_o  (win_halt_s)
  );

  assign win_pc_s = br_new_pc[int'(win_idx_s)*PC_W +: PC_W];

  // Next state; all br_* inputs are wrong-path outside RUN.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pc_d    = pc_q;
    sq_f_d  = 1'b0;
    sq_d_d  = 1'b0;
    sq_e_d  = 1'b0;
    case (state_q)
      RUN: begin
        if (win_valid_s && win_halt_s) begin
          state_d = HALT;
          sq_f_d  = 1'b1;
          sq_d_d  = 1'b1;
        end else if (win_valid_s) begin
          state_d = REDIRECT;
          pc_d    = win_pc_s;
          sq_f_d  = 1'b1;
          sq_d_d  = ~br_dont_squash_dec[win_idx_s];
          sq_e_d  = ~br_dont_squash_exec[win_idx_s];
        end else begin
          state_d = RUN;
        end
      end
      REDIRECT: begin
        if (fetch_ready && (DRAIN_CYCLES > 0)) begin
          state_d = DRAIN;
          cnt_d   = DRAIN_LOAD;
        end else if (fetch_ready) begin
          state_d = RUN;
        end else begin
          state_d = REDIRECT;
        end
      end
      DRAIN: begin
        if (cnt_q <= CNT_W'(1)) begin
          state_d = RUN;
          cnt_d   = '0;
        end else begin
          cnt_d   = cnt_q - CNT_W'(1);
        end
      end
      HALT:    state_d = HALT;
      default: state_d = RUN;
    endcase
    rv_d     = (state_d == REDIRECT);
    stall_d  = (state_d == REDIRECT) || (state_d == HALT);
    halted_d = (state_d == HALT);
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= RUN;
      cnt_q    <= '0;
      pc_q     <= '0;
      rv_q     <= 1'b0;
      sq_f_q   <= 1'b0;
      sq_d_q   <= 1'b0;
      sq_e_q   <= 1'b0;
      stall_q  <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      pc_q     <= pc_d;
      rv_q     <= rv_d;
      sq_f_q   <= sq_f_d;
      sq_d_q   <= sq_d_d;
      sq_e_q   <= sq_e_d;
      stall_q  <= stall_d;
      halted_q <= halted_d;
    end
  end

  assign redirect_valid = rv_q;
  assign redirect_pc    = pc_q;
  assign squash_fetch   = sq_f_q;
  assign squash_dec     = sq_d_q;
  assign squash_exec    = sq_e_q;
  assign stall_front    = stall_q;
  assign halted         = halted_q;

`ifdef BR_REDIRECT_STATS_EN
  logic [31:0] taken_cnt_q;
  logic [31:0] squash_cnt_q;
  logic [31:0] sq_amt_s;

  assign sq_amt_s = {31'd0, sq_f_d} + {31'd0, sq_d_d} + {31'd0, sq_e_d};

  // Event counters; frozen once halted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      taken_cnt_q  <= 32'd0;
      squash_cnt_q <= 32'd0;
    end else if (state_q != HALT) begin
      taken_cnt_q  <= ((state_q == REDIRECT) && fetch_ready) ? sat_add32(taken_cnt_q, 32'd1) : taken_cnt_q;
      squash_cnt_q <= sat_add32(squash_cnt_q, sq_amt_s);
    end else begin
      taken_cnt_q  <= taken_cnt_q;
      squash_cnt_q <= squash_cnt_q;
    end
  end

  assign taken_cnt  = taken_cnt_q;
  assign squash_cnt = squash_cnt_q;
`endif

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Self-checking bench for branch_redirect_ctrl: directed scenarios plus randomized traffic vs a behavioural model.
module tb_branch_redirect_ctrl;

  localparam int N = 2;
  localparam int D = 2;
  localparam int W = 32;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [N-1:0]   br_valid, br_taken, br_dsd, br_dse, br_halt;
  logic [N*W-1:0] br_new_pc;
  logic           fetch_ready;
  logic           redirect_valid, squash_fetch, squash_dec, squash_exec, stall_front, halted;
  logic [W-1:0]   redirect_pc;
`ifdef BR_REDIRECT_STATS_EN
  logic [31:0]    taken_cnt, squash_cnt;
`endif

  int errs = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  branch_redirect_ctrl #(.N_BR(N), .DRAIN_CYCLES(D), .PC_W(W)) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .br_valid            (br_valid),
    .br_taken            (br_taken),
    .br_new_pc           (br_new_pc),
    .br_dont_squash_dec  (br_dsd),
    .br_dont_squash_exec (br_dse),
    .br_halt             (br_halt),
    .fetch_ready         (fetch_ready),
    .redirect_valid      (redirect_valid),
    .redirect_pc         (redirect_pc),
    .squash_fetch        (squash_fetch),
    .squash_dec          (squash_dec),
    .squash_exec         (squash_exec),
    .stall_front         (stall_front),
    .halted              (halted)
`ifdef BR_REDIRECT_STATS_EN
    ,
    .taken_cnt           (taken_cnt),
    .squash_cnt          (squash_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: sticky halt flag, outstanding-redirect flag, cycles of drain left.
  logic        m_halted, m_wait;
  int          m_drain;
  logic [W-1:0] m_pc;
  logic        e_sf, e_sd, e_se;
  int          win;

  function automatic int oldest();
    for (int i = 0; i < N; i++)
      if (br_valid[i] && (br_halt[i] || br_taken[i])) return i;
    return -1;
  endfunction

  always_comb win = oldest();

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_halted <= 1'b0; m_wait <= 1'b0; m_drain <= 0; m_pc <= '0;
      e_sf <= 1'b0; e_sd <= 1'b0; e_se <= 1'b0;
    end else begin
      e_sf <= 1'b0; e_sd <= 1'b0; e_se <= 1'b0;
      if (m_halted) begin
        m_halted <= 1'b1;
      end else if (m_wait) begin
        if (fetch_ready) begin
          m_wait  <= 1'b0;
          m_drain <= D;
        end
      end else if (m_drain > 0) begin
        m_drain <= m_drain - 1;
      end else if (win >= 0) begin
        if (br_halt[win]) begin
          m_halted <= 1'b1; e_sf <= 1'b1; e_sd <= 1'b1;
        end else begin
          m_wait <= 1'b1;
          m_pc   <= br_new_pc[win*W +: W];
          e_sf   <= 1'b1;
          e_sd   <= !br_dsd[win];
          e_se   <= !br_dse[win];
        end
      end
    end
  end

  // Cycle-by-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en && rst_n) begin
      chk("redirect_valid", {31'd0, redirect_valid}, {31'd0, m_wait});
      chk("squash_fetch",   {31'd0, squash_fetch},   {31'd0, e_sf});
      chk("squash_dec",     {31'd0, squash_dec},     {31'd0, e_sd});
      chk("squash_exec",    {31'd0, squash_exec},    {31'd0, e_se});
      chk("stall_front",    {31'd0, stall_front},    {31'd0, m_wait | m_halted});
      chk("halted",         {31'd0, halted},         {31'd0, m_halted});
      if (m_wait) chk("redirect_pc", redirect_pc, m_pc);
    end
  end

  task automatic idle();
    br_valid = '0; br_taken = '0; br_dsd = '0; br_dse = '0; br_halt = '0; br_new_pc = '0;
  endtask

  task automatic slot(input int i, input bit tk, input bit hl, input logic [W-1:0] pc,
                      input bit dsd, input bit dse);
    br_valid[i] = 1'b1; br_taken[i] = tk; br_halt[i] = hl;
    br_new_pc[i*W +: W] = pc; br_dsd[i] = dsd; br_dse[i] = dse;
  endtask

  task automatic nc(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int hcnt;
    idle();
    fetch_ready = 1'b0;
    nc(2);
    chk("reset_rv", {31'd0, redirect_valid}, 32'd0);
    chk("reset_pc", redirect_pc, 32'd0);
    chk("reset_halted", {31'd0, halted}, 32'd0);
    rst_n = 1'b1;
    chk_en = 1'b1;
    nc(1);

    // Slot0 taken to 0x140, full squash, 1-cycle handshake, then drain.
    slot(0, 1'b1, 1'b0, 32'h0000_0140, 1'b0, 1'b0);
    nc(1);
    chk("t1_sq", {29'd0, squash_fetch, squash_dec, squash_exec}, 32'h7);
    chk("t1_pc", redirect_pc, 32'h140);
    chk("t1_rv", {31'd0, redirect_valid}, 32'd1);
    idle(); fetch_ready = 1'b1;
    nc(1);
    chk("t1_rv_drop", {30'd0, redirect_valid, stall_front}, 32'd0);
    fetch_ready = 1'b0;
    nc(3);

    // Slot1 taken to 0x200 keeping decode; fetch stalls 3 cycles; inputs during REDIRECT/DRAIN ignored.
    slot(1, 1'b1, 1'b0, 32'h0000_0200, 1'b1, 1'b0);
    nc(1);
    chk("t2_sq", {29'd0, squash_fetch, squash_dec, squash_exec}, 32'h5);
    idle();
    slot(0, 1'b1, 1'b0, 32'h0000_0999, 1'b0, 1'b0);
    nc(2);
    chk("t2_pc_held", redirect_pc, 32'h200);
    chk("t2_rv_held", {31'd0, redirect_valid}, 32'd1);
    fetch_ready = 1'b1;
    nc(1);
    fetch_ready = 1'b0;
    nc(1);
    chk("t5_drain_nosq", {31'd0, squash_fetch}, 32'd0);
    idle();
    nc(2);

    // Older taken beats younger halt.
    slot(0, 1'b1, 1'b0, 32'h0000_0080, 1'b0, 1'b0);
    slot(1, 1'b0, 1'b1, 32'h0000_0000, 1'b0, 1'b0);
    nc(1);
    chk("t3_pc", redirect_pc, 32'h80);
    chk("t3_halted", {31'd0, halted}, 32'd0);
    idle(); fetch_ready = 1'b1;
    nc(1);
    fetch_ready = 1'b0;
    nc(3);

    // Older halt beats younger taken; sticky until reset.
    slot(0, 1'b0, 1'b1, 32'h0000_0000, 1'b0, 1'b0);
    slot(1, 1'b1, 1'b0, 32'h0000_0300, 1'b0, 1'b0);
    nc(1);
    chk("t4_halt", {27'd0, halted, stall_front, squash_fetch, squash_dec, squash_exec}, 32'h1E);
    idle();
    nc(5);
    slot(0, 1'b1, 1'b0, 32'h0000_0400, 1'b0, 1'b0);
    nc(1);
    chk("t4_no_redirect", {30'd0, redirect_valid, halted}, 32'd1);
    idle();
    #2 rst_n = 1'b0;
    #1 chk("t4_rst_halted", {31'd0, halted}, 32'd0);
    nc(1);
    rst_n = 1'b1;
    nc(1);

    // Asynchronous reset during REDIRECT abandons the redirect.
    slot(0, 1'b1, 1'b0, 32'h0000_0044, 1'b0, 1'b0);
    nc(1);
    idle();
    chk("t6_rv", {31'd0, redirect_valid}, 32'd1);
    #2 rst_n = 1'b0;
    #1 chk("t6_async", {26'd0, redirect_valid, squash_fetch, squash_dec, squash_exec, stall_front, halted}, 32'd0);
    chk("t6_pc", redirect_pc, 32'd0);
    nc(1);
    rst_n = 1'b1;
    slot(1, 1'b1, 1'b0, 32'h0000_0010, 1'b0, 1'b1);
    nc(1);
    chk("t6_run_after", redirect_pc, 32'h10);
    idle(); fetch_ready = 1'b1;
    nc(1);
    fetch_ready = 1'b0;
    nc(3);

    // Randomized traffic; reset a few cycles after every halt.
    hcnt = 0;
    for (int c = 0; c < 600; c++) begin
      if (m_halted) hcnt++;
      else hcnt = 0;
      if (hcnt > 3) begin
        idle();
        #2 rst_n = 1'b0;
        nc(1);
        rst_n = 1'b1;
        hcnt = 0;
      end
      for (int i = 0; i < N; i++) begin
        br_valid[i] = 1'($urandom_range(0, 1));
        br_taken[i] = 1'($urandom_range(0, 2) == 0);
        br_halt[i]  = 1'($urandom_range(0, 40) == 0);
        br_dsd[i]   = 1'($urandom_range(0, 1));
        br_dse[i]   = 1'($urandom_range(0, 1));
        br_new_pc[i*W +: W] = $urandom;
      end
      fetch_ready = 1'($urandom_range(0, 1));
      nc(1);
    end

    idle();
    fetch_ready = 1'b0;
    nc(2);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
